pipelined_add_sub: RTL and testbench

//  Parametrised, carry-pipelined two's-complement adder/subtractor with valid/ready handshake.
//  - Successor to the 8-bit combinational full adder; splits WIDTH into STAGES chunks.
//  - Carry ripples chunk-to-chunk, one register stage per chunk.
//  - Sits between operand producers and a consumer that may stall.

---
 rtl/pipelined_add_sub.sv | 128 ++++++++++++
 tb/tb_pipelined_add_sub.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// Carry-pipelined two's-complement adder/subtractor, one carry chunk per stage.
// Latency: STAGES cycles from input transfer to out_valid; 1 beat/cycle at full rate.
// Backpressure: global advance (adv = !out_valid | out_ready) freezes every stage; in_ready = adv.
// Optional feature: define SATURATE_EN to clamp the sum to signed max/min on overflow.
module pipelined_add_sub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;  // bits handled per stage
  localparam int L  = STAGES - 1;      // index of the final stage

  // Reject geometries the chunking cannot represent.
  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be >= 2 and divisible by STAGES");
  end

  // Per-stage registered state: full-width operands travel along so later stages
  // still see their chunk; s_q accumulates the chunks resolved so far.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;

  // Inputs seen by each stage (stage 0 from the ports, others from the previous stage).
  logic [WIDTH-1:0] a_prev [STAGES];
  logic [WIDTH-1:0] b_prev [STAGES];
  logic [WIDTH-1:0] s_prev [STAGES];
  logic             c_prev [STAGES];

  // Next values computed by each stage.
  logic [CW:0]      chunk  [STAGES];
  logic [WIDTH-1:0] s_d    [STAGES];
  logic             c_d    [STAGES];
  logic             ovf_d;
  logic [WIDTH-1:0] fin_sum;

  logic adv;

  assign adv       = !vld_q[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[L];
  assign sum       = sum_q;
  assign c_out     = c_q[L];
  assign ovf       = ovf_q;

  // Route each stage's operands: subtraction is a + ~b + 1, so invert b and seed the carry.
  always_comb begin
    a_prev[0] = a;
    b_prev[0] = sub ? ~b : b;
    s_prev[0] = '0;
    c_prev[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      a_prev[k] = a_q[k-1];
      b_prev[k] = b_q[k-1];
      s_prev[k] = s_q[k-1];
      c_prev[k] = c_q[k-1];
    end
  end

  // Each stage resolves its own chunk; the final stage also derives overflow and the output sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, a_prev[k][k*CW +: CW]} + {1'b0, b_prev[k][k*CW +: CW]}
               + (CW+1)'(c_prev[k]);
      s_d[k]   = s_prev[k];
      s_d[k][k*CW +: CW] = chunk[k][CW-1:0];
      c_d[k]   = chunk[k][CW];
    end
    ovf_d = (a_prev[L][WIDTH-1] == b_prev[L][WIDTH-1]) &&
            (s_d[L][WIDTH-1] != a_prev[L][WIDTH-1]);
`ifdef SATURATE_EN
    // Overflow direction follows operand A's sign: positive overflow clamps high, negative low.
    if (ovf_d) begin
      fin_sum = a_prev[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      fin_sum = s_d[L];
    end
`else
    fin_sum = s_d[L];
`endif
  end

  // Pipeline registers: everything moves together on adv, everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_prev[k];
        b_q[k] <= b_prev[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      sum_q <= fin_sum;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=8, STAGES=2).
// Reference: signed/unsigned integer arithmetic with an in-order expectation queue.
module tb_pipelined_add_sub;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  logic [W+1:0] exp_q [$];   // {ovf, c_out, sum} per accepted beat
  bit acc;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference result from integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                         input logic xs);
    int sa, sb, ua, ub, res;
    logic o, c;
    logic [W-1:0] s;
    sa  = int'($signed(xa));
    sb  = int'($signed(xb));
    ua  = int'(xa);
    ub  = int'(xb);
    res = xs ? sa - sb : sa + sb;
    o   = (res > (2**(W-1) - 1)) || (res < -(2**(W-1)));
    c   = xs ? (ua >= ub) : (ua + ub > 2**W - 1);
    s   = res[W-1:0];
`ifdef SATURATE_EN
    if (o) s = (res > 0) ? W'(2**(W-1) - 1) : W'(2**(W-1));
`endif
    return {o, c, s};
  endfunction

  // One clock: score transfers at the falling edge, then advance past the rising edge.
  task automatic tick();
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("out_beat", 32'({ovf, c_out, sum}), 32'(exp_q.pop_front()));
    end
    if (acc) exp_q.push_back(model(a, b, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xs, input logic [W-1:0] es, input logic ec, input logic eo);
    a = xa; b = xb; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(c_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    tick();
  endtask

  logic [W-1:0] st_a [3] = '{8'h12, 8'h7F, 8'hF0};
  logic [W-1:0] st_b [3] = '{8'h34, 8'h01, 8'h20};
  logic         st_s [3] = '{1'b0, 1'b0, 1'b1};
  logic [W-1:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

  initial begin
    int idx;

    // Power-on reset.
    #1 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Reset with two beats in flight: outputs clear at once, nothing stale emerges.
    out_ready = 1'b1; in_valid = 1'b1;
    a = 8'h11; b = 8'h22; sub = 1'b0; tick();
    a = 8'h33; b = 8'h44; tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Directed arithmetic corners.
    directed("ff_plus_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef SATURATE_EN
    directed("7f_plus_1", 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    directed("80_minus_1", 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1);
`else
    directed("7f_plus_1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    directed("80_minus_1", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif
    directed("00_minus_1", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);

    // Stall: consumer blocked, pipe fills to two beats, head holds steady.
    out_ready = 1'b0; in_valid = 1'b1; idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      a = st_a[idx]; b = st_b[idx]; sub = st_s[idx];
      tick();
      if (acc) idx++;
      if (cyc >= 1) begin
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        if (exp_q.size() != 0) chk("stall_head", 32'({ovf, c_out, sum}), 32'(exp_q[0]));
      end
    end
    chk("stall_accepted", 32'(idx), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && (idx < 3 || exp_q.size() != 0); cyc++) begin
      if (idx < 3) begin
        a = st_a[idx]; b = st_b[idx]; sub = st_s[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("stall_drain_beats", 32'(idx), 32'd3);
    chk("stall_drain_empty", 32'(exp_q.size()), 32'd0);

    // Sign-boundary operand table with a random consumer.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        for (int s = 0; s < 2; s++) begin
          a = corner[i]; b = corner[j]; sub = s[0]; in_valid = 1'b1;
          do begin
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
          end while (!acc);
        end
      end
    end

    // Random traffic: random operands, random producer gaps, random consumer stalls.
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      a         = W'($urandom);
      b         = W'($urandom);
      sub       = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    // Drain everything still in flight.
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("final_drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
